// File: rtl/stack_alu_exec.sv
// Execution stage behind the stack register: computes op(v1, v0) and returns a pop/push request.
// state | meaning: IDLE wait for start | MUL one shift-add step per cycle | DONE drive result for one cycle
module stack_alu_exec #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             push,
    output logic [1:0]       pop_count,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         pop_q, pop_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] shl_w;

    always_comb begin
        sum_w     = {1'b0, b_q} + {1'b0, a_q};
        diff_w    = {1'b0, b_q} - {1'b0, a_q};
        shl_w     = {{WIDTH{1'b0}}, b_q} << a_q[1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_w[WIDTH-1:0];
                alu_carry = diff_w[WIDTH];
            end
            OP_AND: alu_res = b_q & a_q;
            OP_OR:  alu_res = b_q | a_q;
            OP_XOR: alu_res = b_q ^ a_q;
            OP_MUL: begin
                alu_res   = acc_q[WIDTH-1:0];
                alu_carry = |acc_q[2*WIDTH-1:WIDTH];
            end
            OP_SHL: begin
                alu_res   = shl_w[WIDTH-1:0];
                alu_carry = |shl_w[2*WIDTH-1:WIDTH];
            end
            default: alu_res = ~a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        busy_d   = (state_q == S_MUL);
        done_d   = 1'b0;
        pop_d    = 2'd0;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, b};
                    mplr_d  = a;
                    cnt_d   = CW'(WIDTH);
                    state_d = (op == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d   = 1'b1;
                result_d = alu_res;
                carry_d  = alu_carry;
                pop_d    = (op_q == 3'd7) ? 2'd1 : 2'd2;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pop_q    <= 2'd0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pop_q    <= pop_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign push      = done_q;
    assign pop_count = pop_q;
    assign result    = result_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_stack_alu_exec.sv
// Randomised and directed bench for stack_alu_exec against an arithmetic reference model.
module tb_stack_alu_exec;

    localparam int WIDTH = 4;
    localparam int M     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             push;
    logic [1:0]       pop_count;
    logic [WIDTH-1:0] result;
    logic             carry;

    int checks   = 0;
    int failures = 0;

    stack_alu_exec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .push      (push),
        .pop_count (pop_count),
        .result    (result),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // x is the top of stack (a), y the next entry (b)
    function automatic void model(input int o, input int x, input int y,
                                  output int r, output int c, output int p);
        int t;
        p = 2;
        c = 0;
        r = 0;
        case (o)
            0: begin t = y + x; r = t % M; c = (t >= M) ? 1 : 0; end
            1: begin r = (y - x + M) % M; c = (x > y) ? 1 : 0; end
            2: r = y & x;
            3: r = y | x;
            4: r = y ^ x;
            5: begin t = y * x; r = t % M; c = (t >= M) ? 1 : 0; end
            6: begin t = y * (1 << (x % 4)); r = t % M; c = (t >= M) ? 1 : 0; end
            default: begin r = M - 1 - x; p = 1; end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_push"}, push, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_carry"}, carry, 0);
        check({tag, "_pop"}, pop_count, 0);
    endtask

    task automatic run_op(input int o, input int x, input int y, input bit poke);
        int r, c, p, lat;
        bit seen;
        model(o, x, y, r, c, p);
        lat   = (o == 5) ? WIDTH + 1 : 1;
        op    = 3'(o);
        a     = WIDTH'(x);
        b     = WIDTH'(y);
        start = 1'b1;
        step();
        start = 1'b0;
        op    = 3'($urandom);
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        seen  = 1'b0;
        for (int n = 1; n <= lat + 4 && !seen; n++) begin
            step();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                check($sformatf("lat_op%0d", o), n, lat);
                check($sformatf("push_op%0d", o), push, 1);
                check($sformatf("busy_at_done_op%0d", o), busy, 0);
                check($sformatf("res_op%0d_%0d_%0d", o, x, y), result, r);
                check($sformatf("carry_op%0d_%0d_%0d", o, x, y), carry, c);
                check($sformatf("pop_op%0d", o), pop_count, p);
            end else begin
                check($sformatf("busy_op%0d_n%0d", o, n), busy, (o == 5 && n <= WIDTH) ? 1 : 0);
            end
            if (poke && n == 1) begin
                start = 1'b1;
                op    = 3'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
        end
        if (!seen) check($sformatf("done_timeout_op%0d", o), 0, 1);
        step();
        check("done_falls", done, 0);
        check("push_falls", push, 0);
        check("result_hold", result, r);
        check("carry_hold", carry, c);
        check("pop_clears", pop_count, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b1;
        op    = 3'd5;
        a     = 4'd7;
        b     = 4'd6;
        step();
        step();
        check_all_zero("reset");
        rst   = 1'b1;
        start = 1'b0;
        step();

        run_op(0, 9, 8, 0);
        run_op(1, 5, 3, 0);
        run_op(7, 6, 0, 0);
        run_op(5, 7, 6, 0);
        run_op(5, 3, 5, 0);
        run_op(5, 7, 6, 1);
        run_op(0, 15, 15, 0);
        run_op(1, 15, 0, 0);
        run_op(1, 0, 0, 0);
        run_op(6, 3, 15, 0);
        run_op(6, 0, 9, 0);
        run_op(5, 15, 15, 0);
        run_op(5, 0, 15, 0);
        run_op(7, 0, 0, 0);
        run_op(2, 12, 10, 0);
        run_op(3, 12, 10, 0);
        run_op(4, 12, 10, 0);

        // back-to-back: start held through the DONE state is ignored, then taken in IDLE
        op = 3'd0; a = 4'd9; b = 4'd8; start = 1'b1;
        step();
        op = 3'd1; a = 4'd5; b = 4'd3;
        step();
        check("b2b_first_done", done, 1);
        check("b2b_first_res", result, 1);
        step();
        start = 1'b0;
        check("b2b_gap_done", done, 0);
        check("b2b_gap_res", result, 1);
        step();
        check("b2b_second_done", done, 1);
        check("b2b_second_res", result, 14);
        check("b2b_second_carry", carry, 1);
        step();
        check("b2b_after_done", done, 0);

        // reset in the middle of a multiply
        op = 3'd5; a = 4'd7; b = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b0;
        step();
        check_all_zero("midmul_reset");
        rst = 1'b1;
        for (int n = 0; n < 7; n++) begin
            step();
            check("no_done_after_abort", done, 0);
        end
        run_op(0, 1, 1, 0);

        for (int i = 0; i < 80; i++) begin
            int o;
            o = int'($urandom_range(0, 7));
            run_op(o, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                   (o == 5) ? bit'($urandom_range(0, 1)) : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
